// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: drives the Avalon-MM slave port of an interval timer on
// behalf of fabric clients. It programs the period, starts the timer, clears
// each timeout and reports it as a one-cycle tick.
//
// Optional build macro: TIMER_SEQ_READBACK_EN
//   When defined, the period registers are read back after programming and
//   compared against the request before the timer is started. A mismatch
//   pulses err and tears the timer down instead of starting it.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus idle, waiting for a request
// W_PL      | writing period[15:0] to addr 2
// W_PH      | writing period[31:16] to addr 3
// RB_L      | reading addr 2 (readback build only)
// RB_H      | reading addr 3, capturing addr 2 data (readback build only)
// RB_CMP    | capturing addr 3 data and comparing (readback build only)
// W_CTRL    | writing START|ITO[|CONT] to addr 1
// WAIT      | waiting for tmr_irq
// CLR       | clearing status (addr 0), tick pulse
// S_STOP    | writing STOP with ITO off to addr 1
// S_CLR     | clearing status (addr 0) before returning to IDLE

module timer_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_period,
    input  logic             req_cont,
    input  logic             stop_req,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             done,
    output logic             err
);

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  ADDR_PER_L  = 3'd2;
    localparam logic [2:0]  ADDR_PER_H  = 3'd3;

    localparam logic [15:0] CTRL_ONESHOT = 16'h0005;  // START | ITO
    localparam logic [15:0] CTRL_CONT    = 16'h0007;  // START | CONT | ITO
    localparam logic [15:0] CTRL_STOP    = 16'h0008;  // STOP, ITO off

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_PL,
        ST_W_PH,
`ifdef TIMER_SEQ_READBACK_EN
        ST_RB_L,
        ST_RB_H,
        ST_RB_CMP,
`endif
        ST_W_CTRL,
        ST_WAIT,
        ST_CLR,
        ST_S_STOP,
        ST_S_CLR
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        period_q, period_d;
    logic               cont_q, cont_d;
    logic               stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [2:0]         addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               stop_now;

`ifdef TIMER_SEQ_READBACK_EN
    logic [15:0]        rb_lo_q, rb_lo_d;
`else
    logic               unused_readdata;
    assign unused_readdata = ^tmr_readdata;
`endif

    // Next-state, request latching, stop bookkeeping and tick counting.
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        count_d     = count_q;
        err_d       = 1'b0;
        // A stop arriving this cycle acts like one already pending.
        stop_now    = stop_pend_q | stop_req;
`ifdef TIMER_SEQ_READBACK_EN
        rb_lo_d     = rb_lo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_period != 32'd0) begin
                        state_d  = ST_W_PL;
                        period_d = req_period;
                        cont_d   = req_cont;
                        count_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_W_PL: state_d = stop_now ? ST_S_STOP : ST_W_PH;
`ifdef TIMER_SEQ_READBACK_EN
            ST_W_PH: state_d = stop_now ? ST_S_STOP : ST_RB_L;
            // Readback always runs to the compare so a bad write is reported
            // even when a stop arrives meanwhile.
            ST_RB_L: state_d = ST_RB_H;
            ST_RB_H: begin
                rb_lo_d = tmr_readdata;
                state_d = ST_RB_CMP;
            end
            ST_RB_CMP: begin
                if ({tmr_readdata, rb_lo_q} != period_q) begin
                    err_d   = 1'b1;
                    state_d = ST_S_STOP;
                end else begin
                    state_d = stop_now ? ST_S_STOP : ST_W_CTRL;
                end
            end
`else
            ST_W_PH: state_d = stop_now ? ST_S_STOP : ST_W_CTRL;
`endif
            ST_W_CTRL: state_d = stop_now ? ST_S_STOP : ST_WAIT;
            ST_WAIT: begin
                // A timeout seen together with a stop is serviced first.
                if (tmr_irq) begin
                    state_d = ST_CLR;
                    count_d = count_q + CNT_W'(1);
                end else if (stop_now) begin
                    state_d = ST_S_STOP;
                end
            end
            ST_CLR: begin
                if (stop_now) begin
                    state_d = ST_S_STOP;
                end else if (cont_q) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S_STOP: state_d = ST_S_CLR;
            ST_S_CLR:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && stop_req) begin
            stop_pend_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            stop_pend_d = 1'b0;
        end
    end

    // Bus cycle and status pulses for the state being entered.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        case (state_d)
            ST_W_PL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_PER_L;
                wdata_d = period_d[15:0];
            end
            ST_W_PH: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_PER_H;
                wdata_d = period_d[31:16];
            end
`ifdef TIMER_SEQ_READBACK_EN
            ST_RB_L: begin
                cs_d   = 1'b1;
                addr_d = ADDR_PER_L;
            end
            ST_RB_H: begin
                cs_d   = 1'b1;
                addr_d = ADDR_PER_H;
            end
`endif
            ST_W_CTRL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_CTRL;
                wdata_d = cont_d ? CTRL_CONT : CTRL_ONESHOT;
            end
            ST_CLR, ST_S_CLR: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_STATUS;
                wdata_d = 16'h0000;
            end
            ST_S_STOP: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_CTRL;
                wdata_d = CTRL_STOP;
            end
            default: begin
                cs_d    = 1'b0;
                wn_d    = 1'b1;
                addr_d  = 3'd0;
                wdata_d = 16'h0000;
            end
        endcase
    end

    assign tick_d  = (state_d == ST_CLR);
    assign done_d  = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    assign busy_d  = (state_d != ST_IDLE);
    assign ready_d = (state_d == ST_IDLE);

    // State and all outputs are registered; synchronous reset to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            period_q    <= 32'd0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= 3'd0;
            wdata_q     <= 16'h0000;
`ifdef TIMER_SEQ_READBACK_EN
            rb_lo_q     <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            count_q     <= count_d;
            err_q       <= err_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef TIMER_SEQ_READBACK_EN
            rb_lo_q     <= rb_lo_d;
`endif
        end
    end

    assign req_ready      = ready_q;
    assign busy           = busy_q;
    assign tick           = tick_q;
    assign done           = done_q;
    assign err            = err_q;
    assign tick_count     = count_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_address    = addr_q;
    assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl. The timer is emulated by driving
// tmr_irq / tmr_readdata by hand at the cycles a real timer would.
`timescale 1ns/1ps
module tb_timer_seq_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_period;
    logic             req_cont;
    logic             stop_req;
    logic [2:0]       tmr_address;
    logic             tmr_chipselect;
    logic             tmr_write_n;
    logic [15:0]      tmr_writedata;
    logic [15:0]      tmr_readdata;
    logic             tmr_irq;
    logic             busy;
    logic             tick;
    logic [CNT_W-1:0] tick_count;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    timer_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_period     (req_period),
        .req_cont       (req_cont),
        .stop_req       (stop_req),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq),
        .busy           (busy),
        .tick           (tick),
        .tick_count     (tick_count),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic cs, input logic wn,
                             input logic [2:0] addr, input logic [15:0] data);
        check_val(tag, {11'b0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
                       {11'b0, cs, wn, addr, data});
    endtask

    task automatic check_wr(input string tag, input logic [2:0] addr, input logic [15:0] data);
        check_bus(tag, 1'b1, 1'b0, addr, data);
    endtask

    task automatic check_idle_bus(input string tag);
        check_bus(tag, 1'b0, 1'b1, 3'd0, 16'h0000);
    endtask

    // Let n cycles pass in WAIT; the bus must stay quiet and busy high.
    task automatic wait_quiet(input string tag, input int n);
        int active = 0;
        int not_busy = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (tmr_chipselect !== 1'b0) active++;
            if (busy !== 1'b1) not_busy++;
        end
        check_val({tag, "_quiet"}, 32'(active), 32'd0);
        check_val({tag, "_busy"}, 32'(not_busy), 32'd0);
    endtask

    // Accept a request and check the programming writes up to the CTRL write.
    task automatic start_req(input string tag, input logic [31:0] per, input logic cont);
        req_valid  = 1'b1;
        req_period = per;
        req_cont   = cont;
        step();
        req_valid  = 1'b0;
        check_val({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_val({tag, "_cnt0"}, 32'(tick_count), 32'd0);
        check_wr({tag, "_pl"}, 3'd2, per[15:0]);
        step();
        check_wr({tag, "_ph"}, 3'd3, per[31:16]);
`ifdef TIMER_SEQ_READBACK_EN
        step();
        check_bus({tag, "_rbl"}, 1'b1, 1'b1, 3'd2, 16'h0000);
        step();
        check_bus({tag, "_rbh"}, 1'b1, 1'b1, 3'd3, 16'h0000);
        tmr_readdata = per[15:0];
        step();
        check_idle_bus({tag, "_rbcmp"});
        tmr_readdata = per[31:16];
        step();
        tmr_readdata = 16'h0000;
`else
        step();
`endif
        check_wr({tag, "_ctrl"}, 3'd1, cont ? 16'h0007 : 16'h0005);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_period   = 32'd0;
        req_cont     = 1'b0;
        stop_req     = 1'b0;
        tmr_readdata = 16'h0000;
        tmr_irq      = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (5) step();

        // Reset state after idling.
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_tick",  32'(tick), 32'd0);
        check_val("rst_done",  32'(done), 32'd0);
        check_val("rst_err",   32'(err), 32'd0);
        check_val("rst_cnt",   32'(tick_count), 32'd0);
        check_idle_bus("rst_bus");

        // stop_req in IDLE must be ignored.
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        check_val("idle_stop_busy", 32'(busy), 32'd0);
        step();

        // One-shot, period 9: irq after 10 counts.
        start_req("os", 32'd9, 1'b0);
        wait_quiet("os", 10);
        tmr_irq = 1'b1;
        step();
        check_wr("os_clr", 3'd0, 16'h0000);
        check_val("os_tick", 32'(tick), 32'd1);
        check_val("os_cnt", 32'(tick_count), 32'd1);
        check_val("os_done_early", 32'(done), 32'd0);
        tmr_irq = 1'b0;
        step();
        check_val("os_done", 32'(done), 32'd1);
        check_val("os_ready", 32'(req_ready), 32'd1);
        check_val("os_busy", 32'(busy), 32'd0);
        check_val("os_tick_off", 32'(tick), 32'd0);
        check_idle_bus("os_bus_idle");
        step();
        check_val("os_done_pulse", 32'(done), 32'd0);
        check_val("os_cnt_hold", 32'(tick_count), 32'd1);

        // Continuous, period 0x00010003, three timeouts, then a stop in WAIT.
        start_req("ct", 32'h0001_0003, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_quiet("ct", 4);
            tmr_irq = 1'b1;
            step();
            check_wr("ct_clr", 3'd0, 16'h0000);
            check_val("ct_tick", 32'(tick), 32'd1);
            check_val("ct_cnt", 32'(tick_count), 32'(k + 1));
            tmr_irq = 1'b0;
            step();
            check_val("ct_no_done", 32'(done), 32'd0);
            check_val("ct_busy", 32'(busy), 32'd1);
            check_val("ct_tick_off", 32'(tick), 32'd0);
        end
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        check_wr("ct_stop", 3'd1, 16'h0008);
        step();
        check_wr("ct_sclr", 3'd0, 16'h0000);
        step();
        check_val("ct_done", 32'(done), 32'd1);
        check_val("ct_cnt_final", 32'(tick_count), 32'd3);
        step();

        // Stop in the same cycle as irq: the timeout is still serviced.
        start_req("sx", 32'd5, 1'b1);
        wait_quiet("sx", 3);
        tmr_irq  = 1'b1;
        stop_req = 1'b1;
        step();
        tmr_irq  = 1'b0;
        stop_req = 1'b0;
        check_wr("sx_clr", 3'd0, 16'h0000);
        check_val("sx_tick", 32'(tick), 32'd1);
        step();
        check_wr("sx_stop", 3'd1, 16'h0008);
        check_val("sx_tick_off", 32'(tick), 32'd0);
        step();
        check_wr("sx_sclr", 3'd0, 16'h0000);
        step();
        check_val("sx_done", 32'(done), 32'd1);
        check_val("sx_cnt", 32'(tick_count), 32'd1);
        step();

        // Zero period is rejected.
        req_valid  = 1'b1;
        req_period = 32'd0;
        step();
        req_valid  = 1'b0;
        check_val("zp_err", 32'(err), 32'd1);
        check_val("zp_ready", 32'(req_ready), 32'd1);
        check_val("zp_busy", 32'(busy), 32'd0);
        check_idle_bus("zp_bus");
        step();
        check_val("zp_err_pulse", 32'(err), 32'd0);
        check_idle_bus("zp_bus2");

        // Stop while writing period_l: write completes, then teardown.
        req_valid  = 1'b1;
        req_period = 32'd7;
        req_cont   = 1'b0;
        step();
        req_valid  = 1'b0;
        check_wr("wp_pl", 3'd2, 16'h0007);
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        check_wr("wp_stop", 3'd1, 16'h0008);
        step();
        check_wr("wp_sclr", 3'd0, 16'h0000);
        step();
        check_val("wp_done", 32'(done), 32'd1);
        step();

        // Reset in the middle of WAIT.
        start_req("rs", 32'd20, 1'b0);
        wait_quiet("rs", 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rs_busy", 32'(busy), 32'd0);
        check_val("rs_ready", 32'(req_ready), 32'd1);
        check_val("rs_cnt", 32'(tick_count), 32'd0);
        check_val("rs_done", 32'(done), 32'd0);
        check_idle_bus("rs_bus");
        step();
        check_idle_bus("rs_bus2");

`ifdef TIMER_SEQ_READBACK_EN
        // Readback mismatch on the high half: err, teardown, no start write.
        req_valid  = 1'b1;
        req_period = 32'h0000_5678;
        req_cont   = 1'b0;
        step();
        req_valid  = 1'b0;
        check_wr("rb_pl", 3'd2, 16'h5678);
        step();
        check_wr("rb_ph", 3'd3, 16'h0000);
        step();
        check_bus("rb_rbl", 1'b1, 1'b1, 3'd2, 16'h0000);
        step();
        check_bus("rb_rbh", 1'b1, 1'b1, 3'd3, 16'h0000);
        tmr_readdata = 16'h5678;
        step();
        tmr_readdata = 16'h1234;
        check_idle_bus("rb_cmp");
        step();
        tmr_readdata = 16'h0000;
        check_wr("rb_stop", 3'd1, 16'h0008);
        check_val("rb_err", 32'(err), 32'd1);
        step();
        check_wr("rb_sclr", 3'd0, 16'h0000);
        check_val("rb_err_pulse", 32'(err), 32'd0);
        step();
        check_val("rb_done", 32'(done), 32'd1);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
